// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: bubble instruction,
// FSM state encoding, and the IF/ID and skid buffer layouts.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST_VAL = 32'h0000_0013;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } skid_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register with asynchronous reset to RESET_PC and a load enable.
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else if (we_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem requests, buffers a response when IF/ID
// is blocked, and drains a request orphaned by a redirect before refetching.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_VAL
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pc_write_i,
    input  logic        if_id_write_i,
    input  logic        is_stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_inst_o,
    output logic [31:0] if_id_pc_o,
    output logic        if_id_valid_o,
    output logic [31:0] stall_cycles_o,
    output logic [1:0]  state_o
);

    // Handshake: a request is held (same address) while imem_req_o=1 and
    // imem_ready_i=0; imem_rdata_i is consumed in the cycle both are high.

    logic [1:0]  state_q, state_d;
    if_id_t      if_id_q, if_id_d;
    skid_t       skid_q, skid_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] pc, pc_d;
    logic        pc_we;
    logic        advance;
    logic [31:0] target_al;
    logic [31:0] pc_plus4;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (pc_we),
        .d_i     (pc_d),
        .q_o     (pc)
    );

    assign advance   = pc_write_i & if_id_write_i;
    assign target_al = align_word(redirect_target_i);
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        state_d = state_q;
        if_id_d = if_id_q;
        skid_d  = skid_q;
        pend_d  = pend_q;
        pc_we   = 1'b0;
        pc_d    = pc_plus4;

        // A write slot with nothing delivered becomes a bubble; deliveries below override it.
        if (if_id_write_i) begin
            if_id_d = {NOP_INST, if_id_q.pc, 1'b0};
        end

        case (state_q)
            ST_FETCH: begin
                if (redirect_valid_i) begin
                    if_id_d = {NOP_INST, if_id_q.pc, 1'b0};
                    skid_d  = '0;
                    if (imem_ready_i) begin
                        pc_we = 1'b1;
                        pc_d  = target_al;
                    end else begin
                        pend_d  = target_al;
                        state_d = ST_DROP;
                    end
                end else if (imem_ready_i) begin
                    if (advance) begin
                        if_id_d = {imem_rdata_i, pc, 1'b1};
                        pc_we   = 1'b1;
                    end else begin
                        skid_d  = {imem_rdata_i, pc};
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    if_id_d = {NOP_INST, if_id_q.pc, 1'b0};
                    skid_d  = '0;
                    pc_we   = 1'b1;
                    pc_d    = target_al;
                    state_d = ST_FETCH;
                end else if (advance) begin
                    if_id_d = {skid_q.inst, skid_q.pc, 1'b1};
                    skid_d  = '0;
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (redirect_valid_i) begin
                    if_id_d = {NOP_INST, if_id_q.pc, 1'b0};
                    pend_d  = target_al;
                    if (imem_ready_i) begin
                        pc_we   = 1'b1;
                        pc_d    = target_al;
                        state_d = ST_FETCH;
                    end
                end else if (imem_ready_i) begin
                    pc_we   = 1'b1;
                    pc_d    = pend_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_FETCH;
            if_id_q <= {NOP_INST, 32'h0, 1'b0};
            skid_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            if_id_q <= if_id_d;
            skid_q  <= skid_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (is_stall_i && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign imem_req_o     = (state_q != ST_HOLD);
    assign imem_addr_o    = pc;
    assign if_id_inst_o   = if_id_q.inst;
    assign if_id_pc_o     = if_id_q.pc;
    assign if_id_valid_o  = if_id_q.valid;
    assign stall_cycles_o = stall_cnt_q;
    assign state_o        = state_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-005 pc_write  input  1  from hazard unit; 0 = hold PC.
REQ-006 IF_ID_write  input  1  from hazard unit; 0 = hold IF/ID register.
REQ-007 is_stall  input  1  from hazard unit; load-use stall indicator, counted only.
REQ-008 redirect_valid  input  1  taken branch/jump resolved in EX; flush and redirect.
REQ-009 redirect_target  input  32  new PC on redirect.
REQ-010 imem_req  output  1  instruction-memory request valid.
REQ-011 imem_addr  output  32  request address; word aligned.
REQ-012 imem_ready  input  1  response handshake; imem_rdata valid when imem_req & imem_ready.
REQ-013 imem_rdata  input  32  fetched instruction.
REQ-014 IF_ID_inst / IF_ID_pc  output  32 / 32  IF/ID pipeline register contents.
REQ-015 IF_ID_valid  output  1  1 = IF_ID_inst is a real instruction.
REQ-016 stall_cycles  output  32  saturating count of cycles with is_stall=1.

Function
REQ-017 States: FETCH (request pc), HOLD (response buffered, IF/ID blocked), DROP (finishing a request orphaned by redirect).
REQ-018 FETCH: imem_req=1, imem_addr=pc; HOLD: imem_req=0; DROP: imem_req=1, imem_addr=pc (old, unchanged).
REQ-019 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-020 advance = pc_write & IF_ID_write.
REQ-021 FETCH, accept (imem_ready=1), advance=1, no redirect: IF/ID <= {imem_rdata, pc, valid=1}; pc <= pc+4 (mod 2^32); stay FETCH.
REQ-022 FETCH, accept, advance=0: imem_rdata and pc stored in skid buffer; IF/ID held; go HOLD.
REQ-023 HOLD, advance=1: IF/ID <= {buffer, valid=1}; pc <= pc+4; go FETCH. HOLD, advance=0: hold everything.
REQ-024 No instruction delivered in a cycle with IF_ID_write=1: IF/ID <= {NOP_INST, IF_ID_pc unchanged, valid=0}.
REQ-025 IF_ID_write=0 and no redirect: IF_ID_inst, IF_ID_pc, IF_ID_valid hold.
REQ-026 redirect_valid=1 has priority over IF_ID_write, pc_write and any response: IF/ID <= {NOP_INST, valid=0}; skid buffer discarded.
REQ-027 Redirect in FETCH with imem_ready=1 or in HOLD: pc <= {redirect_target[31:2],2'b00}; go FETCH; same-cycle response discarded.
REQ-028 Redirect in FETCH with imem_ready=0: pending_target <= aligned target; go DROP.
REQ-029 DROP: on imem_ready=1 discard response, pc <= pending_target, go FETCH; redirect while in DROP overwrites pending_target.
REQ-030 stall_cycles increments by 1 each cycle is_stall=1; saturates at 32'hFFFF_FFFF.
REQ-031 Latency: instruction accepted at edge N with advance=1 is visible on IF_ID_* after edge N.

Reset
REQ-032 On reset assertion, immediately: pc=RESET_PC, state=FETCH, IF_ID_inst=NOP_INST, IF_ID_pc=0, IF_ID_valid=0, buffer cleared, pending_target=0, stall_cycles=0.
REQ-033 Reset mid-transaction abandons any in-flight request; first cycle after deassertion issues imem_req=1, imem_addr=RESET_PC.

Structure
REQ-034 NOP_INST value and the FETCH/HOLD/DROP state encoding SHALL live in the shared opcode/constant include.
REQ-035 One sub-module: pc_register (32-bit, async reset to RESET_PC, write enable, load value).

Verification
REQ-036 Reset, imem_ready tied 1, hazard inputs idle -> addresses 0x0,0x4,0x8 on successive cycles; IF_ID_valid=1 from the second cycle.
REQ-037 Accept at pc=0x10 with IF_ID_write=pc_write=0 for 2 cycles -> HOLD, imem_req=0; release -> IF_ID_inst=buffered word, IF_ID_pc=0x10, next address 0x14.
REQ-038 imem_ready=0 for 3 cycles, redirect to 0x103 in cycle 1 -> imem_addr stable at old pc until ready; response dropped; next fetch 0x100; IF_ID_valid=0 throughout.
REQ-039 Redirect to 0x200 concurrent with IF_ID_write=0 -> IF/ID flushed (NOP_INST, valid=0); next fetch 0x200.
REQ-040 is_stall=1 for 5 cycles -> stall_cycles=5; preload at 0xFFFF_FFFE, 3 more -> holds 0xFFFF_FFFF.
REQ-041 Assert reset while in DROP -> outputs at reset values immediately; fetch restarts at RESET_PC.
